// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage: FSM state
// encoding, default widths and the value shown on id_instr when cleared.
package fetch_stage_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    WAIT  = 2'd2,
    PEND  = 2'd3
  } state_t;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/fetch_out_slot.sv
// One-entry valid/ready output register toward decode, plus the pend buffer
// that parks a returned instruction while the slot is still occupied.
module fetch_out_slot
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               deliver,
  input  logic               pend_active,
  input  logic [INSTR_W-1:0] mem_instr,
  input  logic [ADDR_W-1:0]  mem_pc,
  input  logic               id_ready,
  output logic               slot_free,
  output logic               pc_advance,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc
);

  logic               take_mem;
  logic               take_pend;
  logic [INSTR_W-1:0] pend_instr_q;
  logic [ADDR_W-1:0]  pend_pc_q;

  // deliver already excludes flush, so a flushed return never loads anything.
  assign slot_free  = !id_valid || id_ready;
  assign take_mem   = deliver && slot_free;
  assign take_pend  = pend_active && id_ready && !flush;
  assign pc_advance = reset && (take_mem || take_pend);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    if (!reset) begin
      id_valid     <= 1'b0;
      id_instr     <= INSTR_W'(NOP_INSTR);
      id_pc        <= '0;
      pend_instr_q <= '0;
      pend_pc_q    <= '0;
    end else begin
      if (flush) begin
        id_valid <= 1'b0;
      end else if (take_mem) begin
        id_valid <= 1'b1;
        id_instr <= mem_instr;
        id_pc    <= mem_pc;
      end else if (take_pend) begin
        id_valid <= 1'b1;
        id_instr <= pend_instr_q;
        id_pc    <= pend_pc_q;
      end else if (id_valid && id_ready) begin
        id_valid <= 1'b0;
      end

      if (flush) begin
        pend_instr_q <= '0;
        pend_pc_q    <= '0;
      end else if (deliver && !slot_free) begin
        pend_instr_q <= mem_instr;
        pend_pc_q    <= mem_pc;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: samples the PC, runs the req/ack handshake to
// instruction memory and hands results to decode through fetch_out_slot.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_advance,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc
);

  state_t              state_q;
  state_t              state_d;
  logic                discard_q;
  logic [ADDR_W-1:0]   fetch_addr_q;
  logic                deliver;
  logic                pend_active;
  logic                slot_free;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      discard_q    <= 1'b0;
      fetch_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == LATCH) fetch_addr_q <= pc_in;
      // A flush while waiting cannot cancel the request; remember to drop its data.
      if (state_q == WAIT) discard_q <= imem_ack ? 1'b0 : (discard_q || flush);
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = LATCH;
      LATCH: state_d = flush ? LATCH : WAIT;
      WAIT: begin
        if (imem_ack) state_d = (discard_q || flush || slot_free) ? LATCH : PEND;
      end
      PEND: begin
        if (flush || id_ready) state_d = LATCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == WAIT);
    deliver     = imem_req && imem_ack && !discard_q && !flush;
    pend_active = (state_q == PEND);
  end

  assign imem_addr = fetch_addr_q;

  fetch_out_slot #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_slot (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .deliver     (deliver),
    .pend_active (pend_active),
    .mem_instr   (imem_rdata),
    .mem_pc      (fetch_addr_q),
    .id_ready    (id_ready),
    .slot_free   (slot_free),
    .pc_advance  (pc_advance),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a directed cycle table, hand-written flush/reset
// sequences, then random traffic checked against a stream-level model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  logic        mem_auto;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        man_ack;
  logic [31:0] man_rdata;
  logic [31:0] flush_target;
  logic [31:0] pc_model;

  int n_vec;
  int n_fail;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .pc_advance (pc_advance),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ack   = mem_auto ? mem_ack : man_ack;
  assign imem_rdata = mem_auto ? mem_rdata : man_rdata;
  assign pc_in      = pc_model;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Program counter: steps on pc_advance, jumps to the target on flush.
  always @(posedge clk) begin
    if (!reset)          pc_model <= '0;
    else if (flush)      pc_model <= flush_target;
    else if (pc_advance) pc_model <= pc_model + 32'd1;
  end

  // Memory with random 1..4 cycle latency, counted from the first request cycle.
  int mem_cnt;
  int mem_lat;
  always @(negedge clk) begin
    if (!mem_auto || !imem_req) begin
      mem_ack   = 1'b0;
      mem_rdata = 32'hx;
      mem_cnt   = 0;
      mem_lat   = int'($urandom_range(1, 4));
    end else begin
      mem_ack   = (mem_cnt == mem_lat);
      mem_rdata = mem_ack ? mem_word(imem_addr) : 32'hx;
      mem_cnt   = mem_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, fl, ack, rdy;
    logic [31:0] rdata;
    state_t      st;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr, ipc;
    logic        adv;
  } vec_t;

  function automatic vec_t mk(input logic rst, fl, ack, rdy, input logic [31:0] rdata,
                              input state_t st, input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] instr, ipc, input logic adv);
    vec_t v;
    v.rst = rst; v.fl = fl; v.ack = ack; v.rdy = rdy; v.rdata = rdata;
    v.st = st; v.req = req; v.addr = addr; v.vld = vld;
    v.instr = instr; v.ipc = ipc; v.adv = adv;
    return v;
  endfunction

  vec_t vecs[16];

  logic [31:0] exp_pc;
  logic        prev_req;
  logic [31:0] prev_addr;
  int          n_acc;

  initial begin
    n_vec = 0; n_fail = 0;
    reset = 1'b0; flush = 1'b0; id_ready = 1'b0;
    man_ack = 1'b0; man_rdata = '0; mem_auto = 1'b0;
    flush_target = 32'h40;

    //            rst fl ack rdy rdata         st     req addr   vld instr  ipc adv
    vecs[0]  = mk(0, 0, 0, 0, 32'h0,      IDLE,  0, 32'h0,  0, 32'h0,  0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 32'h0,      IDLE,  0, 32'h0,  0, 32'h0,  0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 32'h0,      LATCH, 0, 32'h0,  0, 32'h0,  0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 32'h0,      WAIT,  1, 32'h0,  0, 32'h0,  0, 0);
    vecs[4]  = mk(1, 0, 1, 1, 32'h00A1,   WAIT,  1, 32'h0,  0, 32'h0,  0, 1);
    vecs[5]  = mk(1, 0, 0, 0, 32'h0,      LATCH, 0, 32'h0,  1, 32'hA1, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 32'h0,      WAIT,  1, 32'h1,  1, 32'hA1, 0, 0);
    vecs[7]  = mk(1, 0, 1, 0, 32'h00B2,   WAIT,  1, 32'h1,  1, 32'hA1, 0, 0);
    vecs[8]  = mk(1, 0, 1, 0, 32'hDEAD,   PEND,  0, 32'h0,  1, 32'hA1, 0, 0);
    vecs[9]  = mk(1, 0, 0, 1, 32'h0,      PEND,  0, 32'h0,  1, 32'hA1, 0, 1);
    vecs[10] = mk(1, 0, 0, 1, 32'h0,      LATCH, 0, 32'h0,  1, 32'hB2, 1, 0);
    vecs[11] = mk(1, 0, 0, 1, 32'h0,      WAIT,  1, 32'h2,  0, 32'h0,  0, 0);
    vecs[12] = mk(1, 1, 0, 0, 32'h0,      WAIT,  1, 32'h2,  0, 32'h0,  0, 0);
    vecs[13] = mk(1, 0, 1, 1, 32'h00C3,   WAIT,  1, 32'h2,  0, 32'h0,  0, 0);
    vecs[14] = mk(1, 0, 0, 0, 32'h0,      LATCH, 0, 32'h0,  0, 32'h0,  0, 0);
    vecs[15] = mk(1, 0, 0, 0, 32'h0,      WAIT,  1, 32'h40, 0, 32'h0,  0, 0);

    tick();
    for (int i = 0; i < 16; i++) begin
      reset = vecs[i].rst; flush = vecs[i].fl; id_ready = vecs[i].rdy;
      man_ack = vecs[i].ack; man_rdata = vecs[i].rdata;
      #1;
      check($sformatf("v%0d state", i), 64'(dut.state_q), 64'(vecs[i].st));
      check($sformatf("v%0d imem_req", i), 64'(imem_req), 64'(vecs[i].req));
      if (vecs[i].req || vecs[i].st == IDLE)
        check($sformatf("v%0d imem_addr", i), 64'(imem_addr), 64'(vecs[i].addr));
      check($sformatf("v%0d id_valid", i), 64'(id_valid), 64'(vecs[i].vld));
      if (vecs[i].vld || vecs[i].st == IDLE) begin
        check($sformatf("v%0d id_instr", i), 64'(id_instr), 64'(vecs[i].instr));
        check($sformatf("v%0d id_pc", i), 64'(id_pc), 64'(vecs[i].ipc));
      end
      check($sformatf("v%0d pc_advance", i), 64'(pc_advance), 64'(vecs[i].adv));
      tick();
    end

    // Flush coincident with ack and with a decode transfer.
    man_ack = 1'b1; man_rdata = 32'h51; id_ready = 1'b0; #1;
    check("cf load adv", 64'(pc_advance), 64'd1);
    tick();
    man_ack = 1'b0; #1;
    check("cf slot instr", 64'(id_instr), 64'h51);
    check("cf slot pc", 64'(id_pc), 64'h40);
    tick();
    man_ack = 1'b1; man_rdata = 32'h66; id_ready = 1'b1;
    flush = 1'b1; flush_target = 32'h80; #1;
    check("cf flush adv", 64'(pc_advance), 64'd0);
    check("cf flush addr", 64'(imem_addr), 64'h41);
    tick();
    flush = 1'b0; man_ack = 1'b0; id_ready = 1'b0; #1;
    check("cf valid cleared", 64'(id_valid), 64'd0);
    check("cf state latch", 64'(dut.state_q), 64'(LATCH));
    tick();
    check("cf new req", 64'(imem_req), 64'd1);
    check("cf new addr", 64'(imem_addr), 64'h80);

    // Reset in the middle of a WAIT, then a stale ack while IDLE.
    reset = 1'b0; #1;
    tick();
    check("mr req", 64'(imem_req), 64'd0);
    check("mr valid", 64'(id_valid), 64'd0);
    check("mr state", 64'(dut.state_q), 64'(IDLE));
    reset = 1'b1; man_ack = 1'b1; man_rdata = 32'hEE; #1;
    check("mr late ack adv", 64'(pc_advance), 64'd0);
    tick();
    man_ack = 1'b0; #1;
    check("mr latch", 64'(dut.state_q), 64'(LATCH));
    check("mr valid2", 64'(id_valid), 64'd0);
    tick();
    check("mr restart req", 64'(imem_req), 64'd1);
    check("mr restart addr", 64'(imem_addr), 64'h0);
    tick();
    man_ack = 1'b1; man_rdata = 32'h77; id_ready = 1'b1; #1;
    check("mr adv", 64'(pc_advance), 64'd1);
    tick();
    man_ack = 1'b0; #1;
    check("mr instr", 64'(id_instr), 64'h77);
    check("mr pc", 64'(id_pc), 64'h0);

    // Random traffic against a stream model: decode must see consecutive PCs,
    // restarting at the flush target, each carrying the memory word at that PC.
    reset = 1'b0; mem_auto = 1'b1; id_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    exp_pc = '0; prev_req = 1'b0; prev_addr = '0; n_acc = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c < 2980) begin
        id_ready = ($urandom_range(0, 9) < 7);
        flush    = ($urandom_range(0, 39) == 0);
        if (flush) flush_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      end else begin
        id_ready = 1'b1;
        flush    = 1'b0;
      end
      @(negedge clk);
      if (prev_req && imem_req) check("addr stable", 64'(imem_addr), 64'(prev_addr));
      if (id_valid && id_ready) begin
        check("stream pc", 64'(id_pc), 64'(exp_pc));
        check("stream instr", 64'(id_instr), 64'(mem_word(id_pc)));
        exp_pc = exp_pc + 32'd1;
        n_acc++;
      end
      if (flush) exp_pc = flush_target;
      prev_req  = imem_req;
      prev_addr = imem_addr;
      tick();
    end
    check("stream progress", 64'(n_acc >= 200), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
